// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
// ALU operands, operation and store data are resolved combinationally from the EX registers.
module id_ex_operand_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int REG_ADDR_W    = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     id_valid,
   input  logic [DATA_WIDTH-1:0]    id_pc,
   input  logic [DATA_WIDTH-1:0]    id_rs1_data,
   input  logic [DATA_WIDTH-1:0]    id_rs2_data,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
   input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
   input  logic [REG_ADDR_W-1:0]    id_rd_addr,
   input  logic [OPCODE_LENGTH-1:0] id_alu_op,
   input  logic                     id_alu_src_a,
   input  logic                     id_alu_src_b,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_uses_rs2,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     mem_reg_write,
   input  logic [REG_ADDR_W-1:0]    mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]    mem_result,
   input  logic                     wb_reg_write,
   input  logic [REG_ADDR_W-1:0]    wb_rd_addr,
   input  logic [DATA_WIDTH-1:0]    wb_result,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     ex_valid,
   output logic [DATA_WIDTH-1:0]    ex_pc,
   output logic [REG_ADDR_W-1:0]    ex_rd_addr,
   output logic                     ex_reg_write,
   output logic                     ex_mem_read,
   output logic [DATA_WIDTH-1:0]    ex_store_data,
   output logic                     load_use_stall
);

   localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

   logic                     valid_r;
   logic [DATA_WIDTH-1:0]    pc_r;
   logic [DATA_WIDTH-1:0]    rs1_data_r;
   logic [DATA_WIDTH-1:0]    rs2_data_r;
   logic [DATA_WIDTH-1:0]    imm_r;
   logic [REG_ADDR_W-1:0]    rs1_addr_r;
   logic [REG_ADDR_W-1:0]    rs2_addr_r;
   logic [REG_ADDR_W-1:0]    rd_addr_r;
   logic [OPCODE_LENGTH-1:0] alu_op_r;
   logic                     alu_src_a_r;
   logic                     alu_src_b_r;
   logic                     reg_write_r;
   logic                     mem_read_r;

   logic                     lus_s;
   logic                     bubble_s;
   logic                     load_s;
   logic [DATA_WIDTH-1:0]    fwd1_s;
   logic [DATA_WIDTH-1:0]    fwd2_s;

   // MEM beats WB; x0 and invalid EX slots never take a forwarded value.
   function automatic logic [DATA_WIDTH-1:0] fwd_sel(
      input logic                  en,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [DATA_WIDTH-1:0] rf_data,
      input logic                  m_we,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic [DATA_WIDTH-1:0] m_data,
      input logic                  w_we,
      input logic [REG_ADDR_W-1:0] w_rd,
      input logic [DATA_WIDTH-1:0] w_data
   );
      logic [DATA_WIDTH-1:0] res;
      if (en && m_we && (m_rd == rs) && (rs != REG_X0)) begin
         res = m_data;
      end else if (en && w_we && (w_rd == rs) && (rs != REG_X0)) begin
         res = w_data;
      end else begin
         res = rf_data;
      end
      return res;
   endfunction

   // Hazard detection and register update selection.
   always_comb begin
      lus_s = valid_r && mem_read_r && (rd_addr_r != REG_X0) && id_valid &&
              (((id_rs1_addr == rd_addr_r) && !id_alu_src_a) ||
               (id_uses_rs2 && (id_rs2_addr == rd_addr_r)));
      bubble_s = flush || (!stall && lus_s);
      load_s   = !flush && !stall && !lus_s;
   end

   // EX pipeline register: a bubble clears the whole slot, a stall holds it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || bubble_s) begin
         valid_r     <= 1'b0;
         pc_r        <= {DATA_WIDTH{1'b0}};
         rs1_data_r  <= {DATA_WIDTH{1'b0}};
         rs2_data_r  <= {DATA_WIDTH{1'b0}};
         imm_r       <= {DATA_WIDTH{1'b0}};
         rs1_addr_r  <= REG_X0;
         rs2_addr_r  <= REG_X0;
         rd_addr_r   <= REG_X0;
         alu_op_r    <= {OPCODE_LENGTH{1'b0}};
         alu_src_a_r <= 1'b0;
         alu_src_b_r <= 1'b0;
         reg_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
      end else if (load_s) begin
         valid_r     <= id_valid;
         pc_r        <= id_pc;
         rs1_data_r  <= id_rs1_data;
         rs2_data_r  <= id_rs2_data;
         imm_r       <= id_imm;
         rs1_addr_r  <= id_rs1_addr;
         rs2_addr_r  <= id_rs2_addr;
         rd_addr_r   <= id_rd_addr;
         alu_op_r    <= id_alu_op;
         alu_src_a_r <= id_alu_src_a;
         alu_src_b_r <= id_alu_src_b;
         reg_write_r <= id_reg_write;
         mem_read_r  <= id_mem_read;
      end
   end

   // Operand forwarding and ALU source selection.
   always_comb begin
      fwd1_s = fwd_sel(valid_r, rs1_addr_r, rs1_data_r, mem_reg_write, mem_rd_addr,
                       mem_result, wb_reg_write, wb_rd_addr, wb_result);
      fwd2_s = fwd_sel(valid_r, rs2_addr_r, rs2_data_r, mem_reg_write, mem_rd_addr,
                       mem_result, wb_reg_write, wb_rd_addr, wb_result);
      if (alu_src_a_r) begin
         SrcA = pc_r;
      end else begin
         SrcA = fwd1_s;
      end
      if (alu_src_b_r) begin
         SrcB = imm_r;
      end else begin
         SrcB = fwd2_s;
      end
   end

   assign Operation      = alu_op_r;
   assign ex_valid       = valid_r;
   assign ex_pc          = pc_r;
   assign ex_rd_addr     = rd_addr_r;
   assign ex_reg_write   = valid_r & reg_write_r;
   assign ex_mem_read    = valid_r & mem_read_r;
   assign ex_store_data  = fwd2_s;
   assign load_use_stall = lus_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX outputs are queued when ID
// stimulus is driven and compared one clock later; load_use_stall is checked before the edge.
module tb_id_ex_operand_stage;
   localparam int DW = 32;
   localparam int OW = 4;
   localparam int AW = 5;

   logic          clk, reset;
   logic          id_valid, id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read, id_uses_rs2;
   logic [DW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [OW-1:0] id_alu_op;
   logic          stall, flush, mem_reg_write, wb_reg_write;
   logic [AW-1:0] mem_rd_addr, wb_rd_addr;
   logic [DW-1:0] mem_result, wb_result;
   logic [DW-1:0] SrcA, SrcB, ex_pc, ex_store_data;
   logic [OW-1:0] Operation;
   logic [AW-1:0] ex_rd_addr;
   logic          ex_valid, ex_reg_write, ex_mem_read, load_use_stall;

   typedef struct packed {
      logic          lus;
      logic          full;
      logic          valid;
      logic          rw;
      logic          mr;
      logic [OW-1:0] op;
      logic [DW-1:0] pc;
      logic [AW-1:0] rd;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] st;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   step_no = 0;

   id_ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_alu_op(id_alu_op), .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_uses_rs2(id_uses_rs2),
      .stall(stall), .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr),
      .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
      .wb_result(wb_result), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL step %0d %s: got 0x%h, expected 0x%h", step_no, tag, got, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [DW-1:0] pc,
                         input logic [AW-1:0] rs1, input logic [DW-1:0] rs1d,
                         input logic [AW-1:0] rs2, input logic [DW-1:0] rs2d,
                         input logic [DW-1:0] imm, input logic [AW-1:0] rd, input logic [OW-1:0] op,
                         input logic sa, input logic sb, input logic rw, input logic mr, input logic u2);
      id_valid = v; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = rs1d;
      id_rs2_addr = rs2; id_rs2_data = rs2d; id_imm = imm; id_rd_addr = rd;
      id_alu_op = op; id_alu_src_a = sa; id_alu_src_b = sb;
      id_reg_write = rw; id_mem_read = mr; id_uses_rs2 = u2;
   endtask

   task automatic set_fwd(input logic mw, input logic [AW-1:0] mrd, input logic [DW-1:0] mres,
                          input logic ww, input logic [AW-1:0] wrd, input logic [DW-1:0] wres);
      mem_reg_write = mw; mem_rd_addr = mrd; mem_result = mres;
      wb_reg_write = ww; wb_rd_addr = wrd; wb_result = wres;
   endtask

   task automatic expect_out(input logic lus, input logic full, input logic v, input logic rw,
                             input logic mr, input logic [OW-1:0] op, input logic [DW-1:0] pc,
                             input logic [AW-1:0] rd, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [DW-1:0] st);
      exp_t e;
      e.lus = lus; e.full = full; e.valid = v; e.rw = rw; e.mr = mr; e.op = op;
      e.pc = pc; e.rd = rd; e.a = a; e.b = b; e.st = st;
      sb_q.push_back(e);
   endtask

   // Checks the hazard output before the edge, then the EX outputs after it.
   task automatic step();
      exp_t e;
      step_no++;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL step %0d sb_empty: got 0 entries, expected 1", step_no);
      end else begin
         e = sb_q.pop_front();
         #1;
         check_val("load_use_stall", 32'(load_use_stall), 32'(e.lus));
         @(posedge clk);
         #1;
         check_val("ex_valid", 32'(ex_valid), 32'(e.valid));
         check_val("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
         check_val("ex_mem_read", 32'(ex_mem_read), 32'(e.mr));
         check_val("Operation", 32'(Operation), 32'(e.op));
         if (e.full) begin
            check_val("ex_pc", ex_pc, e.pc);
            check_val("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
            check_val("SrcA", SrcA, e.a);
            check_val("SrcB", SrcB, e.b);
            check_val("ex_store_data", ex_store_data, e.st);
         end
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      set_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) @(negedge clk);
      check_val("rst_ex_valid", 32'(ex_valid), 32'h0);
      check_val("rst_Operation", 32'(Operation), 32'h0);
      check_val("rst_SrcA", SrcA, 32'h0);
      check_val("rst_SrcB", SrcB, 32'h0);
      reset = 1'b0;

      // 1: rs1=x5 forwarded from MEM (0x11) over WB (0x22)
      set_id(1'b1, 32'h40, 5'd5, 32'h55, 5'd6, 32'h66, 32'h8, 5'd7, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 32'h40, 5'd7, 32'h11, 32'h66, 32'h66);
      step();
      // 2-4: stall holds pc 0x40 while forwarding sources change
      @(negedge clk);
      stall = 1'b1;
      set_id(1'b1, 32'h80, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd9, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      set_fwd(1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 32'h40, 5'd7, 32'h22, 32'h66, 32'h66);
      step();
      @(negedge clk);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 32'h40, 5'd7, 32'h55, 32'h66, 32'h66);
      step();
      @(negedge clk);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h77);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 32'h40, 5'd7, 32'h55, 32'h77, 32'h77);
      step();
      // 5: flush wins over stall
      @(negedge clk);
      flush = 1'b1;
      expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      step();
      // 6: x0 source never forwarded
      @(negedge clk);
      stall = 1'b0; flush = 1'b0;
      set_id(1'b1, 32'h10, 5'd1, 32'h3, 5'd0, 32'h0, 32'h0, 5'd2, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 32'h10, 5'd2, 32'h3, 32'h0, 32'h0);
      step();
      // 7: PC/immediate operands, store data still forwarded
      @(negedge clk);
      set_id(1'b1, 32'h100, 5'd8, 32'h123, 5'd9, 32'h999, 32'hFFFFFFFC, 5'd10, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      set_fwd(1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'h0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 32'h100, 5'd10, 32'h100, 32'hFFFFFFFC, 32'hABCD);
      step();
      // 8: lw x3
      @(negedge clk);
      set_id(1'b1, 32'h200, 5'd2, 32'h1000, 5'd0, 32'h0, 32'h4, 5'd3, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h200, 5'd3, 32'h1000, 32'h4, 32'h0);
      step();
      // 9: add x4,x3,x1 -> load-use bubble
      @(negedge clk);
      set_id(1'b1, 32'h204, 5'd3, 32'h0, 5'd1, 32'h5, 32'h0, 5'd4, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      expect_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      step();
      // 10: add enters, x3 from WB
      @(negedge clk);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hCAFE);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h4, 32'h204, 5'd4, 32'hCAFE, 32'h5, 32'h5);
      step();
      // 11: lw x0
      @(negedge clk);
      set_id(1'b1, 32'h300, 5'd2, 32'h10, 5'd0, 32'h0, 32'h8, 5'd0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h300, 5'd0, 32'h10, 32'h8, 32'h0);
      step();
      // 12: reads x0 after lw x0 -> no hazard; this is lw x6
      @(negedge clk);
      set_id(1'b1, 32'h304, 5'd0, 32'h0, 5'd0, 32'h0, 32'h20, 5'd6, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h304, 5'd6, 32'h0, 32'h20, 32'h0);
      step();
      // 13: rs1=x6 but operand A is PC -> no hazard
      @(negedge clk);
      set_id(1'b1, 32'h308, 5'd6, 32'h11, 5'd0, 32'h0, 32'h1000, 5'd9, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 32'h308, 5'd9, 32'h308, 32'h1000, 32'h0);
      step();
      // 14: lw x6 again
      @(negedge clk);
      set_id(1'b1, 32'h30C, 5'd0, 32'h0, 5'd0, 32'h0, 32'h20, 5'd6, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h30C, 5'd6, 32'h0, 32'h20, 32'h0);
      step();
      // 15: store of x6 -> rs2 load-use bubble
      @(negedge clk);
      set_id(1'b1, 32'h310, 5'd7, 32'h700, 5'd6, 32'h0, 32'h4, 5'd0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      expect_out(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      step();
      // 16: store enters, MEM beats WB for x6
      @(negedge clk);
      set_fwd(1'b1, 5'd6, 32'h99, 1'b1, 5'd6, 32'h66);
      expect_out(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h310, 5'd0, 32'h700, 32'h4, 32'h99);
      step();
      // 17: invalid ID slot gates reg_write
      @(negedge clk);
      set_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      expect_out(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
      step();
      // 18: lw x3, then reset mid-stream with a dependent add in ID
      @(negedge clk);
      set_id(1'b1, 32'h400, 5'd2, 32'h1000, 5'd0, 32'h0, 32'h4, 5'd3, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      expect_out(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h400, 5'd3, 32'h1000, 32'h4, 32'h0);
      step();
      @(negedge clk);
      set_id(1'b1, 32'h404, 5'd3, 32'h0, 5'd1, 32'h5, 32'h0, 5'd4, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      set_fwd(1'b1, 5'd2, 32'h55, 1'b1, 5'd2, 32'h66);
      #1;
      check_val("lus_before_reset", 32'(load_use_stall), 32'h1);
      reset = 1'b1;
      #1;
      check_val("reset_ex_valid", 32'(ex_valid), 32'h0);
      check_val("reset_Operation", 32'(Operation), 32'h0);
      check_val("reset_SrcA", SrcA, 32'h0);
      check_val("reset_SrcB", SrcB, 32'h0);
      check_val("reset_load_use_stall", 32'(load_use_stall), 32'h0);
      check_val("reset_ex_reg_write", 32'(ex_reg_write), 32'h0);
      check_val("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
